// File: rtl/quiz_pkg.sv
// Shared types and codes for the two-player quiz round controller.
// Remote nibbles are active-low one-hot: nibble bit 3 is answer 1, bit 0 is answer 4.
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ASK,
    ST_RESULT,
    ST_DONE
  } state_t;

  localparam int NUM_PLAYERS = 2;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  // LSB of each player's nibble inside rm_in_bcd
  localparam int P1_LSB = 4;
  localparam int P2_LSB = 0;

  function automatic logic [2:0] decode_nibble(input logic [3:0] nib);
    case (nib)
      4'b0111: decode_nibble = 3'd1;
      4'b1011: decode_nibble = 3'd2;
      4'b1101: decode_nibble = 3'd3;
      4'b1110: decode_nibble = 3'd4;
      default: decode_nibble = 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] pick_winner(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2)      pick_winner = WIN_P1;
    else if (s2 > s1) pick_winner = WIN_P2;
    else              pick_winner = WIN_TIE;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    sat_inc = (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/quiz_remote_decode.sv
// Remote input conditioning: 2-flop synchronizer, per-player one-hot decode,
// and a rising-edge press pulse (no-press -> valid press only).
module quiz_remote_decode
  import quiz_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rm_in_bcd,
  output logic [NUM_PLAYERS-1:0]            press,
  output logic [NUM_PLAYERS-1:0][2:0]       ans,
  output logic                              released
);

  logic [7:0]                        sync1, sync2;
  logic [NUM_PLAYERS-1:0][2:0]       ans_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
      ans_q <= '0;
    end else begin
      sync1 <= rm_in_bcd;
      sync2 <= sync1;
      ans_q <= ans;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    localparam int LSB = (p == 0) ? P1_LSB : P2_LSB;
    assign ans[p]   = decode_nibble(sync2[LSB +: 4]);
    assign press[p] = (ans[p] != 3'd0) && (ans_q[p] == 3'd0);
  end

  assign released = &sync2;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Two-player quiz round sequencer: arms on full button release, judges first
// presses against the problem ROM, tracks scores, lockouts and the final winner.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int NUM_PROB    = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int RESULT_CYC  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rm_in_bcd,
  input  logic [3:0] prob_ans,
  output logic [3:0] prob_idx,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] result,
  output logic       lockout_p1,
  output logic       lockout_p2,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TMAX = (TIMEOUT_CYC > RESULT_CYC) ? TIMEOUT_CYC : RESULT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  state_t                         state;
  logic [TW-1:0]                  timer;
  logic [NUM_PLAYERS-1:0]         lock;
  logic [NUM_PLAYERS-1:0][3:0]    score;
  logic                           ptr;  // 0: player 1 wins ties, 1: player 2

  logic [NUM_PLAYERS-1:0]         press, elig, judge, hit, miss, lock_nxt;
  logic [NUM_PLAYERS-1:0][2:0]    ans;
  logic                           released, tie, ans_ok;

  quiz_remote_decode u_decode (
    .clk       (clk),
    .rst       (rst),
    .rm_in_bcd (rm_in_bcd),
    .press     (press),
    .ans       (ans),
    .released  (released)
  );

  // At most one player is judged per cycle; a tie goes to the pointer's player.
  assign elig     = press & ~lock;
  assign tie      = &elig;
  assign judge[0] = elig[0] & (~elig[1] | ~ptr);
  assign judge[1] = elig[1] & (~elig[0] |  ptr);
  assign ans_ok   = (prob_ans >= 4'd1) && (prob_ans <= 4'd4);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_judge
    assign hit[p]  = judge[p] && ans_ok && ({1'b0, ans[p]} == prob_ans);
    assign miss[p] = judge[p] && !hit[p];
  end

  assign lock_nxt = lock | miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      lock      <= '0;
      score     <= '0;
      ptr       <= 1'b0;
      prob_idx  <= 4'd0;
      result    <= RES_NONE;
      busy      <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            score     <= '0;
            lock      <= '0;
            prob_idx  <= 4'd0;
            result    <= RES_NONE;
            winner    <= WIN_NONE;
            busy      <= 1'b1;
            game_over <= 1'b0;
            state     <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (released) begin
            timer <= TW'(TIMEOUT_CYC);
            state <= ST_ASK;
          end
        end
        ST_ASK: begin
          if (tie) ptr <= ~ptr;
          // A correct press outranks a timeout landing on the same edge
          if (|hit) begin
            if (hit[0]) score[0] <= sat_inc(score[0]);
            else        score[1] <= sat_inc(score[1]);
            result <= hit[0] ? RES_P1 : RES_P2;
            timer  <= TW'(RESULT_CYC);
            state  <= ST_RESULT;
          end else begin
            lock <= lock_nxt;
            if ((&lock_nxt) || (timer <= TW'(1))) begin
              result <= RES_NONE;
              timer  <= TW'(RESULT_CYC);
              state  <= ST_RESULT;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        ST_RESULT: begin
          if (timer <= TW'(1)) begin
            if (prob_idx == 4'(NUM_PROB - 1)) begin
              busy      <= 1'b0;
              game_over <= 1'b1;
              winner    <= pick_winner(score[0], score[1]);
              state     <= ST_DONE;
            end else begin
              prob_idx <= prob_idx + 4'd1;
              lock     <= '0;
              result   <= RES_NONE;
              state    <= ST_ARM;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign score_p1   = score[0];
  assign score_p2   = score[1];
  assign lockout_p1 = lock[0];
  assign lockout_p2 = lock[1];

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed game scenarios plus random button traffic,
// every cycle compared against a rule-level reference model.
module tb_quiz_round_ctrl;

  localparam int NP = 16;
  localparam int TO = 40;
  localparam int RC = 5;

  localparam int PH_IDLE = 0, PH_ARM = 1, PH_ASK = 2, PH_SHOW = 3, PH_OVER = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] rm;
  logic [3:0] prob_ans;
  logic [3:0] prob_idx, score_p1, score_p2;
  logic [1:0] result, winner;
  logic       lockout_p1, lockout_p2, busy, game_over;

  logic [3:0] rom [NP];

  // reference model state
  logic [7:0] q[$];
  int prev [2];
  int sc   [2];
  int lk   [2];
  int ph, left, res, pri, win, m_idx;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign prob_ans = rom[m_idx];

  quiz_round_ctrl #(.NUM_PROB(NP), .TIMEOUT_CYC(TO), .RESULT_CYC(RC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rm_in_bcd  (rm),
    .prob_ans   (prob_ans),
    .prob_idx   (prob_idx),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .result     (result),
    .lockout_p1 (lockout_p1),
    .lockout_p2 (lockout_p2),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // answer held on a nibble: exactly one low bit counts, anything else is no press
  function automatic int dec(input logic [3:0] nib);
    int lows = 0;
    int a = 0;
    for (int k = 0; k < 4; k++)
      if (!nib[3-k]) begin lows++; a = k + 1; end
    return (lows == 1) ? a : 0;
  endfunction

  function automatic logic [3:0] code(input int a);
    logic [3:0] n = 4'hF;
    if (a >= 1 && a <= 4) n[4-a] = 1'b0;
    return n;
  endfunction

  task automatic m_reset();
    q = '{8'hFF, 8'hFF};
    prev = '{0, 0}; sc = '{0, 0}; lk = '{0, 0};
    ph = PH_IDLE; left = 0; res = 0; pri = 1; win = 0; m_idx = 0;
  endtask

  task automatic m_edge();
    logic [7:0] cur;
    int a [2];
    int pr [2];
    int who, pa;
    bit good;
    cur = q[0];
    void'(q.pop_front());
    q.push_back(rm);
    a[0] = dec(cur[7:4]);
    a[1] = dec(cur[3:0]);
    for (int p = 0; p < 2; p++) begin
      pr[p] = (a[p] != 0 && prev[p] == 0);
      prev[p] = a[p];
    end
    case (ph)
      PH_IDLE, PH_OVER:
        if (start) begin
          sc = '{0, 0}; lk = '{0, 0}; m_idx = 0; res = 0; win = 0; ph = PH_ARM;
        end
      PH_ARM:
        if (cur == 8'hFF) begin left = TO; ph = PH_ASK; end
      PH_ASK: begin
        who = 0;
        pa = int'(rom[m_idx]);
        if (pr[0] && !lk[0] && pr[1] && !lk[1]) begin who = pri; pri = 3 - pri; end
        else if (pr[0] && !lk[0]) who = 1;
        else if (pr[1] && !lk[1]) who = 2;
        good = (who != 0) && (pa >= 1) && (pa <= 4) && (a[who-1] == pa);
        if (good) begin
          if (sc[who-1] < 15) sc[who-1]++;
          res = who; left = RC; ph = PH_SHOW;
        end else begin
          if (who != 0) lk[who-1] = 1;
          if ((lk[0] && lk[1]) || left == 1) begin res = 0; left = RC; ph = PH_SHOW; end
          else left--;
        end
      end
      PH_SHOW:
        if (left == 1) begin
          if (m_idx == NP - 1) begin
            ph = PH_OVER;
            win = (sc[0] > sc[1]) ? 1 : (sc[1] > sc[0]) ? 2 : 3;
          end else begin
            m_idx++; lk = '{0, 0}; res = 0; ph = PH_ARM;
          end
        end else left--;
      default: ;
    endcase
  endtask

  task automatic cmp_all();
    chk("prob_idx",   prob_idx,   m_idx);
    chk("score_p1",   score_p1,   sc[0]);
    chk("score_p2",   score_p2,   sc[1]);
    chk("result",     result,     res);
    chk("lockout_p1", lockout_p1, lk[0]);
    chk("lockout_p2", lockout_p2, lk[1]);
    chk("busy",       busy,       (ph == PH_ARM || ph == PH_ASK || ph == PH_SHOW));
    chk("game_over",  game_over,  (ph == PH_OVER));
    chk("winner",     winner,     win);
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ask();
    int n = 0;
    while (ph != PH_ASK && n < 200) begin tick(); n++; end
    chk("wait_ask_bound", (n < 200), 1);
  endtask

  task automatic rand_rm();
    int a;
    if ($urandom_range(3) == 0) begin
      a = int'(rom[m_idx]);
      case ($urandom_range(5))
        0: rm = 8'hFF;
        1: rm = {code($urandom_range(4, 1)), 4'hF};
        2: rm = {4'hF, code($urandom_range(4, 1))};
        3: rm = {code($urandom_range(4, 1)), code($urandom_range(4, 1))};
        4: rm = 8'($urandom);
        default: rm = ($urandom_range(1) == 0) ? {code(a), 4'hF} : {4'hF, code(a)};
      endcase
    end
  endtask

  initial begin
    int n;
    logic [3:0] g1 [NP] = '{4'd2, 4'd3, 4'd3, 4'd4, 4'd1, 4'd0, 4'd7, 4'd12,
                             4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1};
    rom = g1;
    rst = 1'b1; start = 1'b0; rm = 8'hFF;
    m_reset();
    @(negedge clk);
    cmp_all();
    rst = 1'b0;
    ticks(2);

    // game 1: directed problems 0..5, then random traffic
    pulse_start();
    wait_ask();
    rm = 8'hBF;                       // player 1, answer 2: correct
    ticks(3);
    chk("p1_first_score", score_p1, 1);
    chk("p1_first_result", result, 1);
    rm = 8'hFF;
    ticks(RC - 1);
    chk("result_hold_idx", prob_idx, 0);
    tick();
    chk("result_end_idx", prob_idx, 1);

    wait_ask();
    rm = 8'h7F;                       // player 1, answer 1: wrong
    ticks(3);
    chk("p1_lockout", lockout_p1, 1);
    rm = 8'hFF; ticks(2);
    rm = 8'hFD;                       // player 2, answer 3: correct
    ticks(3);
    chk("p2_score", score_p2, 1);
    chk("p2_result", result, 2);
    rm = 8'hFF;

    wait_ask();
    rm = 8'hDD;                       // tie, pointer on player 1
    ticks(3);
    chk("tie1_p1", score_p1, 2);
    rm = 8'hFF;
    wait_ask();
    rm = 8'hEE;                       // tie, pointer now on player 2
    ticks(3);
    chk("tie2_p2", score_p2, 2);
    rm = 8'hFF;

    wait_ask();
    ticks(TO);                        // silent problem times out
    chk("timeout_result", result, 0);
    chk("timeout_s1", score_p1, 2);
    chk("timeout_s2", score_p2, 2);

    wait_ask();
    rm = 8'hBF;                       // invalid ROM answer, held through to next ARM
    ticks(TO + RC + 10);
    chk("stall_busy", busy, 1);
    chk("stall_idx", prob_idx, 6);
    rm = 8'hFF;

    n = 0;
    while (ph != PH_OVER && n < 4000) begin rand_rm(); tick(); n++; end
    chk("game1_done_bound", (n < 4000), 1);
    chk("game1_over", game_over, 1);
    rm = 8'hFF;
    ticks(3);

    // game 2: player 1 answers every problem correctly, score saturates
    for (int i = 0; i < NP; i++) rom[i] = 4'(1 + (i % 4));
    pulse_start();
    chk("restart_s1", score_p1, 0);
    chk("restart_s2", score_p2, 0);
    n = 0;
    while (ph != PH_OVER && n < 4000) begin
      rm = (ph == PH_ASK) ? {code(int'(rom[m_idx])), 4'hF} : 8'hFF;
      tick();
      n++;
    end
    chk("game2_done_bound", (n < 4000), 1);
    chk("sat_score", score_p1, 15);
    chk("sat_winner", winner, 1);
    chk("sat_over", game_over, 1);
    rm = 8'hFF;

    // game 3: asynchronous reset in the middle of a problem
    pulse_start();
    wait_ask();
    rm = 8'h7F;
    ticks(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_idx", prob_idx, 0);
    chk("arst_s1", score_p1, 0);
    chk("arst_s2", score_p2, 0);
    chk("arst_res", result, 0);
    chk("arst_lk", {lockout_p1, lockout_p2}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_over", game_over, 0);
    chk("arst_win", winner, 0);
    m_reset();
    rm = 8'hFF;
    #1 rst = 1'b0;
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 Parameter NUM_PROB, default 8: problems per game, range 1..16.
REQ-002 Parameter TIMEOUT_CYC, default 1000: answer window per problem, in clk cycles.
REQ-003 Parameter RESULT_CYC, default 200: result display hold, in clk cycles.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins or restarts a game.
REQ-007 rm_in_bcd  in  8  raw remote buttons, active-low. Bits [7:4] are player 1 answers 1..4; bits [3:0] are player 2 answers 1..4.
REQ-008 prob_ans  in  4  correct answer for prob_idx, combinational from the problem ROM; valid values are 1..4.
REQ-009 prob_idx  out  4  current problem index.
REQ-010 score_p1, score_p2  out  4 each  player scores, binary.
REQ-011 result  out  2  0 = none, 1 = player 1 correct, 2 = player 2 correct; valid in RESULT state.
REQ-012 lockout_p1, lockout_p2  out  1 each  player is barred for the current problem.
REQ-013 busy  out  1  high in any state except IDLE and DONE.
REQ-014 game_over  out  1  high in DONE.
REQ-015 winner  out  2  0 = none, 1 = player 1, 2 = player 2, 3 = tie; valid in DONE.

Function
REQ-016 rm_in_bcd passes through a 2-flop synchronizer; all following logic uses only the synchronized value.
REQ-017 Per-player decode: a press is valid only when exactly one of that player's 4 bits is low; multiple low bits count as no press.
REQ-018 A press event fires when a player's decoded value goes from "no press" to a valid press; held buttons do not retrigger.
REQ-019 States are IDLE, ARM, ASK, RESULT, DONE.
REQ-020 IDLE or DONE, on start: clear scores, lockouts, prob_idx and result; go to ARM. start is ignored in all other states.
REQ-021 ARM: wait until all 8 synchronized bits are high, then load the timer with TIMEOUT_CYC and go to ASK.
REQ-022 ASK: press events from players who are not locked out are judged against prob_ans.
REQ-023 Correct press: that player's score increments, saturating at 15; result is set to that player; go to RESULT.
REQ-024 Wrong press: set that player's lockout and stay in ASK. If both players are locked out, result = 0 and go to RESULT.
REQ-025 prob_ans outside 1..4: every press is judged wrong.
REQ-026 Simultaneous valid presses from both players in one cycle: only the player named by the priority pointer is judged. The pointer resets to player 1 and toggles after each tie it resolves. The other player's press is discarded.
REQ-027 Timer reaches 0 in ASK with no correct press: result = 0, go to RESULT.
REQ-028 A correct press in the same cycle as timer expiry wins over the timeout.
REQ-029 RESULT lasts RESULT_CYC cycles. Then: if prob_idx == NUM_PROB-1, go to DONE and leave prob_idx unchanged; otherwise increment prob_idx, clear both lockouts and result, and go to ARM.
REQ-030 DONE: winner = the higher score, or 3 if scores are equal (including 0 = 0).
REQ-031 Latency: score and result update on the 3rd rising edge after the first edge that samples the new rm_in_bcd value.

Reset
REQ-032 rst drives, immediately: state IDLE, prob_idx 0, both scores 0, result 0, both lockouts 0, busy 0, game_over 0, winner 0, timers 0, priority pointer = player 1, synchronizer flops all 1.
REQ-033 rst asserted in any state, including mid-ASK or mid-RESULT, abandons the game; no score is retained.

Structure
REQ-034 Package quiz_pkg holds the state enum, the result/winner codes, and the player-nibble positions in rm_in_bcd.
REQ-035 Sub-module quiz_remote_decode holds the synchronizer, per-player decode and edge detect. Its outputs per player are a press pulse and a 3-bit answer (0 = none).

Verification
REQ-036 start; prob_ans = 2; rm_in_bcd = 8'hBF (player 1, answer 2) -> score_p1 = 1 and result = 1 after 3 edges; RESULT lasts exactly RESULT_CYC cycles; prob_idx goes to 1.
REQ-037 Player 1 presses 8'h7F (answer 1, wrong) with prob_ans = 3, then player 2 presses 8'hFD (answer 3) -> lockout_p1 = 1, then score_p2 = 1 and result = 2.
REQ-038 Same cycle, rm_in_bcd = 8'hDD (player 1 answer 3, player 2 answer 3), prob_ans = 3 -> player 1 scores. On the next problem, 8'hEE with prob_ans = 4 -> player 2 scores (pointer toggled).
REQ-039 No press for TIMEOUT_CYC cycles -> result = 0, scores unchanged. A button held from the previous problem stalls ARM until it is released.
REQ-040 NUM_PROB = 2; player 1 correct twice -> game_over = 1, winner = 1. A new start clears scores to 0. Also: 16 correct answers on a large game -> score saturates at 15.
REQ-041 rst pulsed in mid-ASK -> every output takes its REQ-032 value asynchronously, before the next clk edge.
